// File: rtl/sisc_pkg.sv
// Shared constants and state encoding for the data-memory arbiter.
package sisc_pkg;

   localparam int unsigned SISC_ADDR_W = 16;
   localparam int unsigned SISC_DATA_W = 32;
   localparam int unsigned CNT_W       = 4;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester (cpu, dbg) and data-memory signal bundle for dm_arbiter.
interface dm_arbiter_if
   import sisc_pkg::*;
#(
   parameter int unsigned ADDR_W = SISC_ADDR_W,
   parameter int unsigned DATA_W = SISC_DATA_W
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_ack;
   logic [DATA_W-1:0] dbg_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  mem_rdata,
      output cpu_ack, cpu_rdata, cpu_stall,
      output dbg_ack, dbg_rdata,
      output mem_addr, mem_wdata, mem_we
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output mem_rdata,
      input  cpu_ack, cpu_rdata, cpu_stall,
      input  dbg_ack, dbg_rdata,
      input  mem_addr, mem_wdata, mem_we
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way winner pick for dm_arbiter; DM_ARB_CPU_PRIORITY_EN selects fixed
// cpu priority instead of round-robin on ties.
module rr_arb2
   import sisc_pkg::*;
(
   input  logic i_cpu_req,
   input  logic i_dbg_req,
   input  logic i_last_grant,
   output logic o_any_c,
   output logic o_win_c
);

   assign o_any_c = i_cpu_req | i_dbg_req;

`ifdef DM_ARB_CPU_PRIORITY_EN
   logic w_unused_last;
   assign w_unused_last = i_last_grant;
   assign o_win_c       = i_cpu_req ? PORT_CPU : PORT_DBG;
`else
   // On a tie the port that was not served last wins.
   always_comb begin
      o_win_c = PORT_CPU;
      if (i_cpu_req && i_dbg_req) begin
         o_win_c = ~i_last_grant;
      end else if (i_dbg_req) begin
         o_win_c = PORT_DBG;
      end
   end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Shares single-port data memory between cpu and dbg requesters with
// req/ack handshakes and WAIT_STATES extra cycles per access.
// Optional macro DM_ARB_CPU_PRIORITY_EN: fixed cpu priority (see rr_arb2).
module dm_arbiter
   import sisc_pkg::*;
#(
   parameter int unsigned ADDR_W      = SISC_ADDR_W,
   parameter int unsigned DATA_W      = SISC_DATA_W,
   parameter int unsigned WAIT_STATES = 1
)(
   input  logic        clk,
   input  logic        rst_f,
   dm_arbiter_if.slave bus
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_last_grant;
   logic              r_win;
   logic              r_we;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_we;
   logic              r_cpu_ack;
   logic              r_dbg_ack;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_dbg_rdata;

   logic              w_any;
   logic              w_win;
   logic              w_grant;
   logic              w_last_cycle;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   rr_arb2 u_rr_arb2 (
      .i_cpu_req    (bus.cpu_req),
      .i_dbg_req    (bus.dbg_req),
      .i_last_grant (r_last_grant),
      .o_any_c      (w_any),
      .o_win_c      (w_win)
   );

   assign w_sel_we    = (w_win == PORT_DBG) ? bus.dbg_we    : bus.cpu_we;
   assign w_sel_addr  = (w_win == PORT_DBG) ? bus.dbg_addr  : bus.cpu_addr;
   assign w_sel_wdata = (w_win == PORT_DBG) ? bus.dbg_wdata : bus.cpu_wdata;

   always_ff @(posedge clk) begin
      if (rst_f) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant      = 1'b0;
      w_last_cycle = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_grant     = 1'b1;
               w_state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (r_cnt == '0) begin
               w_last_cycle = 1'b1;
               w_state_nxt  = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Grant latches the request; the write strobe lives only in the first ACCESS cycle.
   always_ff @(posedge clk) begin
      if (rst_f) begin
         r_last_grant <= PORT_DBG;
         r_win        <= PORT_CPU;
         r_we         <= 1'b0;
         r_cnt        <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_we     <= 1'b0;
         r_cpu_ack    <= 1'b0;
         r_dbg_ack    <= 1'b0;
         r_cpu_rdata  <= '0;
         r_dbg_rdata  <= '0;
      end else begin
         r_mem_we  <= 1'b0;
         r_cpu_ack <= 1'b0;
         r_dbg_ack <= 1'b0;
         if (w_grant) begin
            r_win        <= w_win;
            r_last_grant <= w_win;
            r_we         <= w_sel_we;
            r_mem_addr   <= w_sel_addr;
            r_mem_wdata  <= w_sel_wdata;
            r_mem_we     <= w_sel_we;
            r_cnt        <= CNT_W'(WAIT_STATES);
         end else if ((r_state == ACCESS) && !w_last_cycle) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_last_cycle) begin
            if (r_win == PORT_DBG) begin
               r_dbg_ack <= 1'b1;
               if (!r_we) r_dbg_rdata <= bus.mem_rdata;
            end else begin
               r_cpu_ack <= 1'b1;
               if (!r_we) r_cpu_rdata <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_we    = r_mem_we;
   assign bus.cpu_ack   = r_cpu_ack;
   assign bus.dbg_ack   = r_dbg_ack;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.dbg_rdata = r_dbg_rdata;
   assign bus.cpu_stall = bus.cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed cases plus randomized
// transactions against a transaction-level reference model.
module tb_dm_arbiter;
   import sisc_pkg::*;

   localparam int unsigned WS    = 1;
   localparam int unsigned AW    = SISC_ADDR_W;
   localparam int unsigned DW    = SISC_DATA_W;
   localparam int          LIMIT = 4 * int'(WS) + 12;
`ifdef DM_ARB_CPU_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_f;
   int   n_checks = 0;
   int   n_errors = 0;

   dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
      .clk   (clk),
      .rst_f (rst_f),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory the DUT talks to: combinational read, clocked write.
   logic [DW-1:0] phys_mem [256];
   assign bus.mem_rdata = phys_mem[bus.mem_addr[7:0]];
   always @(posedge clk) if (bus.mem_we) phys_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;

   // Reference model state.
   logic [DW-1:0] ref_mem [256];
   logic          m_last;
   logic [DW-1:0] m_rdata [2];
   logic          q_we    [2];
   logic [AW-1:0] q_addr  [2];
   logic [DW-1:0] q_wdata [2];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic model_winner(input logic c, input logic d);
      if (c && d) return PRIO ? PORT_CPU : ~m_last;
      return c ? PORT_CPU : PORT_DBG;
   endfunction

   task automatic set_port(input logic p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
      q_we[p] = we; q_addr[p] = a; q_wdata[p] = d;
      if (p == PORT_CPU) begin
         bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
      end else begin
         bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
      end
   endtask

   task automatic mutate_port(input logic p);
      if (p == PORT_CPU) begin
         bus.cpu_we = ~q_we[p]; bus.cpu_addr = q_addr[p] ^ 16'h0010; bus.cpu_wdata = ~q_wdata[p];
      end else begin
         bus.dbg_we = ~q_we[p]; bus.dbg_addr = q_addr[p] ^ 16'h0010; bus.dbg_wdata = ~q_wdata[p];
      end
   endtask

   // Model completion of an access by port p: update memory or read value.
   task automatic model_complete(input logic p);
      if (q_we[p]) ref_mem[q_addr[p][7:0]] = q_wdata[p];
      else         m_rdata[p] = ref_mem[q_addr[p][7:0]];
      m_last = p;
   endtask

   task automatic model_reset();
      m_last     = PORT_DBG;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
   endtask

   // One request from each enabled port; requesters drop req on their ack.
   task automatic run_txn(input bit c_en, input bit d_en, input bit mutate);
      logic order [2];
      int   exp_t [2];
      int   n, idx, we_seen, cpu_t;
      bit   done;
      logic cur, p;
      n        = (c_en && d_en) ? 2 : 1;
      order[0] = model_winner(c_en, d_en);
      order[1] = ~order[0];
      exp_t[0] = int'(WS) + 2;
      exp_t[1] = 2 * int'(WS) + 5;
      cpu_t    = (order[0] == PORT_CPU) ? exp_t[0] : exp_t[1];
      idx = 0; we_seen = 0; done = 1'b0;
      @(negedge clk);
      bus.cpu_req = c_en;
      bus.dbg_req = d_en;
      for (int t = 1; t <= LIMIT && !done; t++) begin
         @(negedge clk);
         cur = order[idx];
         if (mutate && t == 1) mutate_port(order[0]);
         check_eq("stall", 64'(bus.cpu_stall), 64'(c_en && (t < cpu_t)));
         check_eq("ack_excl", 64'(bus.cpu_ack & bus.dbg_ack), 64'(0));
         if (bus.mem_we) begin
            we_seen++;
            check_eq("wr_addr", 64'(bus.mem_addr), 64'(q_addr[cur]));
            check_eq("wr_data", 64'(bus.mem_wdata), 64'(q_wdata[cur]));
         end
         if (bus.cpu_ack || bus.dbg_ack) begin
            p = bus.dbg_ack ? PORT_DBG : PORT_CPU;
            check_eq("ack_port", 64'(p), 64'(cur));
            check_eq("ack_time", 64'(t), 64'(exp_t[idx]));
            check_eq("we_count", 64'(we_seen), 64'(q_we[cur] ? 1 : 0));
            model_complete(cur);
            check_eq("rdata", 64'((cur == PORT_DBG) ? bus.dbg_rdata : bus.cpu_rdata),
                     64'(m_rdata[cur]));
            if (p == PORT_DBG) bus.dbg_req = 1'b0;
            else               bus.cpu_req = 1'b0;
            idx++;
            we_seen = 0;
            if (idx == n) done = 1'b1;
         end
      end
      if (!done) check_eq("timeout", 64'(idx), 64'(n));
      bus.cpu_req = 1'b0;
      bus.dbg_req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acks, we_cnt, dbg_acks, cpu_acks, mode;
      logic p, exp_p;
      for (int i = 0; i < 256; i++) begin
         phys_mem[i] = '0;
         ref_mem[i]  = '0;
      end
      rst_f = 1'b1;
      bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
      set_port(PORT_CPU, 1'b0, '0, '0);
      set_port(PORT_DBG, 1'b0, '0, '0);
      model_reset();

      // Reset held two cycles.
      repeat (2) @(negedge clk);
      check_eq("rst_acks", 64'({bus.cpu_ack, bus.dbg_ack}), 64'(0));
      check_eq("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'(0));
      check_eq("rst_dbg_rdata", 64'(bus.dbg_rdata), 64'(0));
      check_eq("rst_mem_we", 64'(bus.mem_we), 64'(0));
      check_eq("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
      check_eq("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
      check_eq("rst_stall", 64'(bus.cpu_stall), 64'(0));
      rst_f = 1'b0;

      // cpu write then read back.
      set_port(PORT_CPU, 1'b1, 16'h0010, 32'hDEADBEEF);
      run_txn(1'b1, 1'b0, 1'b0);
      set_port(PORT_CPU, 1'b0, 16'h0010, 32'h0);
      run_txn(1'b1, 1'b0, 1'b0);
      check_eq("readback", 64'(bus.cpu_rdata), 64'(32'hDEADBEEF));

      // Reset in the second ACCESS cycle of a cpu write.
      set_port(PORT_CPU, 1'b1, 16'h0005, 32'hA5A50005);
      @(negedge clk); bus.cpu_req = 1'b1;
      @(negedge clk);
      check_eq("mid_strobe", 64'(bus.mem_we), 64'(1));
      @(negedge clk);
      rst_f = 1'b1; bus.cpu_req = 1'b0;
      @(negedge clk);
      check_eq("mid_acks", 64'({bus.cpu_ack, bus.dbg_ack}), 64'(0));
      check_eq("mid_mem_we", 64'(bus.mem_we), 64'(0));
      check_eq("mid_mem_addr", 64'(bus.mem_addr), 64'(0));
      check_eq("mid_cpu_rdata", 64'(bus.cpu_rdata), 64'(0));
      rst_f = 1'b0;
      ref_mem[5] = 32'hA5A50005;
      model_reset();

      // Both requesting continuously for four grants.
      set_port(PORT_CPU, 1'b0, 16'h0001, 32'h0);
      set_port(PORT_DBG, 1'b1, 16'h0002, 32'h12345678);
      @(negedge clk); bus.cpu_req = 1'b1; bus.dbg_req = 1'b1;
      acks = 0;
      for (int t = 1; t <= 4 * LIMIT && acks < 4; t++) begin
         @(negedge clk);
         check_eq("alt_excl", 64'(bus.cpu_ack & bus.dbg_ack), 64'(0));
         if (bus.cpu_ack || bus.dbg_ack) begin
            p     = bus.dbg_ack ? PORT_DBG : PORT_CPU;
            exp_p = model_winner(1'b1, 1'b1);
            check_eq("alt_order", 64'(p), 64'(exp_p));
            model_complete(exp_p);
            check_eq("alt_rdata", 64'((exp_p == PORT_DBG) ? bus.dbg_rdata : bus.cpu_rdata),
                     64'(m_rdata[exp_p]));
            acks++;
         end
      end
      bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
      check_eq("alt_count", 64'(acks), 64'(4));

      // Fields changed after grant are ignored; then confirm 0x30 untouched.
      set_port(PORT_DBG, 1'b1, 16'h0020, 32'hCAFE0020);
      run_txn(1'b0, 1'b1, 1'b1);
      set_port(PORT_DBG, 1'b0, 16'h0030, 32'h0);
      run_txn(1'b0, 1'b1, 1'b0);
      check_eq("addr30_clean", 64'(bus.dbg_rdata), 64'(0));

      // dbg req raised and dropped while cpu access is in flight.
      set_port(PORT_CPU, 1'b0, 16'h0003, 32'h0);
      set_port(PORT_DBG, 1'b1, 16'h0040, 32'hBAD00040);
      @(negedge clk); bus.cpu_req = 1'b1;
      we_cnt = 0; dbg_acks = 0; cpu_acks = 0;
      for (int t = 1; t <= int'(WS) + 6; t++) begin
         @(negedge clk);
         if (t == 1) bus.dbg_req = 1'b1;
         if (t == 2) bus.dbg_req = 1'b0;
         if (bus.mem_we) we_cnt++;
         if (bus.dbg_ack) dbg_acks++;
         if (bus.cpu_ack) begin
            cpu_acks++;
            bus.cpu_req = 1'b0;
            model_complete(PORT_CPU);
         end
      end
      check_eq("drop_no_we", 64'(we_cnt), 64'(0));
      check_eq("drop_no_ack", 64'(dbg_acks), 64'(0));
      check_eq("drop_cpu_ack", 64'(cpu_acks), 64'(1));

      // Randomized traffic.
      for (int it = 0; it < 60; it++) begin
         mode = int'($urandom_range(1, 3));
         set_port(PORT_CPU, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
         set_port(PORT_DBG, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
         run_txn(mode[0], mode[1], 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
